// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bundle for the forwarding/hazard unit.
// The pipeline drives through the master modport, and the unit uses the slave modport.
interface fwd_hazard_unit_if #(
    parameter int N_SRC  = 2,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [N_SRC*REG_AW-1:0] rs_id_ex;
    logic [N_SRC*REG_AW-1:0] rs_if_id;
    logic [N_SRC-1:0]        use_if_id;
    logic [REG_AW-1:0]       rd_id_ex;
    logic                    mem_read_id_ex;
    logic [REG_AW-1:0]       rd_ex_mem;
    logic                    reg_write_ex_mem;
    logic [REG_AW-1:0]       rd_mem_wb;
    logic                    reg_write_mem_wb;
    logic                    pipe_flush;
    logic                    clr_stats;
    logic [N_SRC*2-1:0]      fwd_sel;
    logic                    stall_if;
    logic                    stall_id;
    logic                    flush_ex;
    logic [CNT_W-1:0]        stall_count;
    logic [CNT_W-1:0]        fwd_count;

    modport master (
        output rs_id_ex, rs_if_id, use_if_id, rd_id_ex, mem_read_id_ex,
               rd_ex_mem, reg_write_ex_mem, rd_mem_wb, reg_write_mem_wb,
               pipe_flush, clr_stats,
        input  fwd_sel, stall_if, stall_id, flush_ex, stall_count, fwd_count
    );

    modport slave (
        input  rs_id_ex, rs_if_id, use_if_id, rd_id_ex, mem_read_id_ex,
               rd_ex_mem, reg_write_ex_mem, rd_mem_wb, reg_write_mem_wb,
               pipe_flush, clr_stats,
        output fwd_sel, stall_if, stall_id, flush_ex, stall_count, fwd_count
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// RAW forwarding selects for the EX operand muxes, and load-use stall sequencing.
// The unit also keeps saturating statistics counters.
//   state | meaning
//   IDLE  | no stall in progress; a load-use hit stalls this cycle
//   HOLD  | remaining bubbles of a multi-cycle load-use stall (cnt_q left)
module fwd_hazard_unit #(
    parameter int N_SRC       = 2,
    parameter int REG_AW      = 5,
    parameter int LOAD_STALLS = 1,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               arst_n,
    fwd_hazard_unit_if.slave   bus
);
    typedef enum logic {IDLE, HOLD} state_e;

    localparam logic [3:0]       CNT_INIT = 4'(LOAD_STALLS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   fwd_cnt_q, fwd_cnt_d;
    logic [N_SRC*2-1:0] fwd_sel;
    logic               hit;
    logic               stall_raw;
    logic               stall;

    wire ex_fwd_ok = bus.reg_write_ex_mem && (bus.rd_ex_mem != '0);
    wire wb_fwd_ok = bus.reg_write_mem_wb && (bus.rd_mem_wb != '0);

    // EX/MEM beats MEM/WB because it holds the younger result.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (ex_fwd_ok && (bus.rd_ex_mem == bus.rs_id_ex[i*REG_AW +: REG_AW]))
                fwd_sel[2*i +: 2] = 2'b10;
            else if (wb_fwd_ok && (bus.rd_mem_wb == bus.rs_id_ex[i*REG_AW +: REG_AW]))
                fwd_sel[2*i +: 2] = 2'b01;
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (bus.use_if_id[i] && (bus.rs_if_id[i*REG_AW +: REG_AW] == bus.rd_id_ex))
                hit = 1'b1;
        end
        hit = hit && bus.mem_read_id_ex && (bus.rd_id_ex != '0);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        if (bus.pipe_flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        stall_raw = 1'b1;
                        if (LOAD_STALLS > 1) begin
                            cnt_d   = CNT_INIT;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    stall_raw = 1'b1;
                    cnt_d     = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // A load-use hit is combinational, so stall is gated with reset to stay low in reset.
    assign stall = stall_raw && arst_n;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (bus.clr_stats) begin
            stall_cnt_d = '0;
            fwd_cnt_d   = '0;
        end else begin
            if (stall && (stall_cnt_q != '1))
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            if ((fwd_sel != '0) && (fwd_cnt_q != '1))
                fwd_cnt_d = fwd_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign bus.fwd_sel     = fwd_sel;
    assign bus.stall_if    = stall;
    assign bus.stall_id    = stall;
    assign bus.flush_ex    = stall;
    assign bus.stall_count = stall_cnt_q;
    assign bus.fwd_count   = fwd_cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit.
// It drives two instances from the same stimulus: LOAD_STALLS=1/CNT_W=16 and LOAD_STALLS=3/CNT_W=4.
module tb_fwd_hazard_unit;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.N_SRC(2), .REG_AW(5), .CNT_W(16)) bus1 ();
    fwd_hazard_unit_if #(.N_SRC(2), .REG_AW(5), .CNT_W(4))  bus3 ();

    assign bus3.rs_id_ex         = bus1.rs_id_ex;
    assign bus3.rs_if_id         = bus1.rs_if_id;
    assign bus3.use_if_id        = bus1.use_if_id;
    assign bus3.rd_id_ex         = bus1.rd_id_ex;
    assign bus3.mem_read_id_ex   = bus1.mem_read_id_ex;
    assign bus3.rd_ex_mem        = bus1.rd_ex_mem;
    assign bus3.reg_write_ex_mem = bus1.reg_write_ex_mem;
    assign bus3.rd_mem_wb        = bus1.rd_mem_wb;
    assign bus3.reg_write_mem_wb = bus1.reg_write_mem_wb;
    assign bus3.pipe_flush       = bus1.pipe_flush;
    assign bus3.clr_stats        = bus1.clr_stats;

    fwd_hazard_unit #(.N_SRC(2), .REG_AW(5), .LOAD_STALLS(1), .CNT_W(16)) dut1 (
        .clk(clk), .arst_n(arst_n), .bus(bus1)
    );
    fwd_hazard_unit #(.N_SRC(2), .REG_AW(5), .LOAD_STALLS(3), .CNT_W(4)) dut3 (
        .clk(clk), .arst_n(arst_n), .bus(bus3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stall(input string tag, input logic exp1, input logic exp3);
        chk({tag, " d1.stall_if"}, 32'(bus1.stall_if), 32'(exp1));
        chk({tag, " d1.stall_id"}, 32'(bus1.stall_id), 32'(exp1));
        chk({tag, " d1.flush_ex"}, 32'(bus1.flush_ex), 32'(exp1));
        chk({tag, " d3.stall_if"}, 32'(bus3.stall_if), 32'(exp3));
        chk({tag, " d3.stall_id"}, 32'(bus3.stall_id), 32'(exp3));
        chk({tag, " d3.flush_ex"}, 32'(bus3.flush_ex), 32'(exp3));
    endtask

    task automatic set_hit(input logic [1:0] use_v);
        bus1.mem_read_id_ex = 1'b1;
        bus1.rd_id_ex       = 5'd4;
        bus1.rs_if_id       = {5'd0, 5'd4};
        bus1.use_if_id      = use_v;
    endtask

    initial begin
        bus1.rs_id_ex         = '0;
        bus1.rs_if_id         = '0;
        bus1.use_if_id        = '0;
        bus1.rd_id_ex         = '0;
        bus1.mem_read_id_ex   = 1'b0;
        bus1.rd_ex_mem        = '0;
        bus1.reg_write_ex_mem = 1'b0;
        bus1.rd_mem_wb        = '0;
        bus1.reg_write_mem_wb = 1'b0;
        bus1.pipe_flush       = 1'b0;
        bus1.clr_stats        = 1'b0;

        // Check the reset state. A load-use hit during reset must not stall.
        set_hit(2'b01);
        #12;
        chk_stall("reset hit", 1'b0, 1'b0);
        chk("reset d1.stall_count", 32'(bus1.stall_count), 32'd0);
        chk("reset d3.fwd_count", 32'(bus3.fwd_count), 32'd0);
        bus1.mem_read_id_ex = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        cyc();

        // Forwarding.
        bus1.rs_id_ex = {5'd5, 5'd5};
        bus1.rd_ex_mem = 5'd5; bus1.rd_mem_wb = 5'd5;
        bus1.reg_write_ex_mem = 1'b1; bus1.reg_write_mem_wb = 1'b1;
        #1 chk("fwd both match", 32'(bus1.fwd_sel), 32'b1010);
        bus1.reg_write_ex_mem = 1'b0;
        #1 chk("fwd wb only", 32'(bus1.fwd_sel), 32'b0101);
        bus1.reg_write_ex_mem = 1'b1;
        bus1.rs_id_ex = '0; bus1.rd_ex_mem = '0; bus1.rd_mem_wb = '0;
        #1 chk("fwd x0", 32'(bus1.fwd_sel), 32'b0000);
        bus1.rs_id_ex = {5'd7, 5'd3}; bus1.rd_ex_mem = 5'd7; bus1.rd_mem_wb = 5'd3;
        #1 chk("fwd split", 32'(bus3.fwd_sel), 32'b1001);
        bus1.rs_id_ex = {5'd9, 5'd5}; bus1.rd_ex_mem = 5'd5; bus1.reg_write_mem_wb = 1'b0;
        #1 chk("fwd port0 only", 32'(bus1.fwd_sel), 32'b0010);
        bus1.reg_write_ex_mem = 1'b0; bus1.rs_id_ex = '0;
        bus1.rd_ex_mem = '0; bus1.rd_mem_wb = '0;
        #1 chk("fwd none", 32'(bus1.fwd_sel), 32'b0000);

        bus1.clr_stats = 1'b1;
        cyc();
        bus1.clr_stats = 1'b0;
        chk("clr d1.fwd_count", 32'(bus1.fwd_count), 32'd0);

        // Load-use hit: dut1 stalls for 1 cycle and dut3 stalls for 3 cycles.
        set_hit(2'b01);
        #1 chk_stall("lu c1", 1'b1, 1'b1);
        cyc();
        bus1.mem_read_id_ex = 1'b0;
        #1 chk_stall("lu c2", 1'b0, 1'b1);
        cyc();
        #1 chk_stall("lu c3", 1'b0, 1'b1);
        cyc();
        #1 chk_stall("lu c4", 1'b0, 1'b0);
        chk("lu d1.stall_count", 32'(bus1.stall_count), 32'd1);
        chk("lu d3.stall_count", 32'(bus3.stall_count), 32'd3);

        // If the matching port is not used, there is no stall.
        set_hit(2'b00);
        #1 chk_stall("unused port", 1'b0, 1'b0);
        cyc();
        chk("unused d3.stall_count", 32'(bus3.stall_count), 32'd3);
        bus1.mem_read_id_ex = 1'b0;

        // Flush in the second stall cycle.
        set_hit(2'b01);
        #1 chk_stall("fl c1", 1'b1, 1'b1);
        cyc();
        bus1.mem_read_id_ex = 1'b0; bus1.pipe_flush = 1'b1;
        #1 chk_stall("fl c2", 1'b0, 1'b0);
        cyc();
        bus1.pipe_flush = 1'b0;
        #1 chk_stall("fl after", 1'b0, 1'b0);
        chk("fl d3.stall_count", 32'(bus3.stall_count), 32'd4);
        chk("fl d1.stall_count", 32'(bus1.stall_count), 32'd2);

        // A flush concurrent with a hit in IDLE blocks the stall and does not enter HOLD.
        set_hit(2'b01); bus1.pipe_flush = 1'b1;
        #1 chk_stall("fl+hit", 1'b0, 1'b0);
        cyc();
        bus1.mem_read_id_ex = 1'b0; bus1.pipe_flush = 1'b0;
        #1 chk_stall("fl+hit next", 1'b0, 1'b0);
        cyc();

        // A reset pulse in HOLD does not resume the stall after release.
        set_hit(2'b01);
        cyc();
        bus1.mem_read_id_ex = 1'b0;
        #1 chk_stall("rst pre", 1'b0, 1'b1);
        arst_n = 1'b0;
        #1 chk_stall("rst during", 1'b0, 1'b0);
        chk("rst d3.stall_count", 32'(bus3.stall_count), 32'd0);
        chk("rst d1.stall_count", 32'(bus1.stall_count), 32'd0);
        arst_n = 1'b1;
        cyc();
        #1 chk_stall("rst after", 1'b0, 1'b0);
        chk("rst after d3.stall_count", 32'(bus3.stall_count), 32'd0);

        // fwd_count saturates for CNT_W=4, and clr wins over forwarding.
        bus1.rs_id_ex = {5'd0, 5'd5}; bus1.rd_ex_mem = 5'd5; bus1.reg_write_ex_mem = 1'b1;
        repeat (20) cyc();
        chk("sat d3.fwd_count", 32'(bus3.fwd_count), 32'd15);
        chk("sat d1.fwd_count", 32'(bus1.fwd_count), 32'd20);
        bus1.clr_stats = 1'b1;
        cyc();
        chk("clr d3.fwd_count", 32'(bus3.fwd_count), 32'd0);
        chk("clr d1.fwd_count2", 32'(bus1.fwd_count), 32'd0);
        bus1.clr_stats = 1'b0;
        cyc();
        chk("post clr d3.fwd_count", 32'(bus3.fwd_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
